// File: rtl/shift_seq_pkg.sv
// Shared constants and state encoding for the sequential left shifter.
package shift_seq_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SHIFT_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Width of the stage counter, which must be able to hold 0..SHIFT_WIDTH.
  function automatic int stage_w(input int shift_width);
    return $clog2(shift_width + 1);
  endfunction

endpackage

// File: rtl/shift_l_stage.sv
// One power-of-two barrel stage: shifts left by 2**stage when enabled.
module shift_l_stage #(
  parameter int WIDTH = 8,
  parameter int STW   = 2
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [STW-1:0]   stage,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = data << (32'd1 << stage);
    result  = en ? shifted : data;
  end

endmodule

// File: rtl/shift_l_seq_int8.sv
// Handshaked left shifter resolving one power-of-two stage of the shift amount per clock.
module shift_l_seq_int8
  import shift_seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [1:0]       dbg_state
);

  localparam int STW = stage_w(SHIFT_WIDTH);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic [SHIFT_WIDTH-1:0] amt_q, amt_d;
  logic [STW-1:0]         stage_q, stage_d;
  logic [WIDTH-1:0]       stage_out;

  shift_l_stage #(
    .WIDTH (WIDTH),
    .STW   (STW)
  ) u_stage (
    .data   (acc_q),
    .en     (amt_q[stage_q]),
    .stage  (stage_q),
    .result (stage_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
    end
  end

  // Both ports use valid/ready: a transfer happens on a rising clk edge where
  // valid and ready are both high; a producer holds valid and data until then.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    stage_d = stage_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = A;
          amt_d   = B[SHIFT_WIDTH-1:0];
          stage_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // No early exit: every stage is walked even when amt is zero.
        acc_d   = stage_out;
        stage_d = stage_q + STW'(1);
        if (stage_q == STW'(SHIFT_WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Y         = (state_q == ST_DONE) ? acc_q : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_l_seq_int8.sv
// Directed and sweep bench for shift_l_seq_int8 with an expected-value scoreboard.
module tb_shift_l_seq_int8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y_out;
  logic [1:0] dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_res  = 0;

  logic       sb_en    = 1'b0;
  logic       rand_rdy = 1'b0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_y     = '0;

  shift_l_seq_int8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (y_out),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    a_in     = $urandom_range(0, 255);
    b_in     = $urandom_range(0, 255);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_y);
    accept(a, b);
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    tick();
    tick();
    check({tag, "_lat2"}, {31'd0, out_valid}, 32'd0);
    tick();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_y"}, {24'd0, y_out}, {24'd0, exp_y});
    tick();
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_y0"}, {24'd0, y_out}, 32'd0);
  endtask

  // scoreboard: a transfer will occur at the next rising edge
  always @(negedge clk) begin
    if (sb_en && out_valid) begin
      if (prev_stall) check("hold_y", {24'd0, y_out}, {24'd0, prev_y});
      if (out_ready) begin
        if (exp_q.size() == 0) check("sb_empty", {24'd0, y_out}, 32'hFFFF_FFFF);
        else check("sweep_y", {24'd0, y_out}, {24'd0, exp_q.pop_front()});
        n_res++;
      end
    end
    prev_stall = sb_en && out_valid && !out_ready;
    prev_y     = y_out;
  end

  initial begin
    logic [15:0] wide;
    int          waited;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {24'd0, y_out}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_op("t1", 8'h01, 8'h07, 8'h80);
    run_op("t2", 8'hB5, 8'hFB, 8'hA8);
    run_op("t3", 8'h5C, 8'h00, 8'h5C);

    // backpressure with a competing operand held during DONE
    out_ready = 1'b0;
    accept(8'h0F, 8'h02);
    tick();
    tick();
    tick();
    in_valid = 1'b1;
    a_in     = 8'hFF;
    b_in     = 8'h01;
    for (int i = 0; i < 4; i++) begin
      check("t4_valid", {31'd0, out_valid}, 32'd1);
      check("t4_y", {24'd0, y_out}, 32'h3C);
      check("t4_no_accept", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t4_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("t4_second_busy", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    tick();
    check("t4_second_valid", {31'd0, out_valid}, 32'd1);
    check("t4_second_y", {24'd0, y_out}, 32'hFE);
    tick();

    // reset in the second SHIFT cycle
    accept(8'h03, 8'h05);
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_y", {24'd0, y_out}, 32'd0);
    check("t5_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t5_no_stale", {31'd0, out_valid}, 32'd0);
      tick();
    end
    run_op("t5_after", 8'h03, 8'h05, 8'h60);

    // sweep every A and shift amount with random stalls and gaps
    sb_en    = 1'b1;
    rand_rdy = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int s = 0; s < 8; s++) begin
        logic [7:0] b;
        b      = 8'($urandom_range(0, 255));
        b[2:0] = 3'(s);
        wide   = {8'd0, 8'(a)} << s;
        exp_q.push_back(wide[7:0]);
        accept(8'(a), b);
        n_acc++;
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      tick();
      waited++;
    end
    check("drain", exp_q.size(), 32'd0);
    tick();
    sb_en    = 1'b0;
    rand_rdy = 1'b0;
    check("res_count", n_res, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
